// File: rtl/mpc_vsub_pkg.sv
// Shared types and constants for the constraint-stage vector-subtract scheduler.
// Holds the sequencer state encoding, saturation bounds and requester count.
package mpc_vsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  localparam int unsigned N_REQ = 2;

endpackage

// File: rtl/mpc_sat_sub.sv
// Combinational signed subtract r = sat(a - b) with one guard bit; b is
// sign-extended to the operand width. Requires BW <= DW.
module mpc_sat_sub #(
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 21
) (
  input  logic [DW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [DW-1:0] r
);

  logic [DW:0] a_x;
  logic [DW:0] b_x;
  logic [DW:0] ret;

  assign a_x = {a[DW-1], a};
  assign b_x = {{(DW + 1 - BW){b[BW-1]}}, b};
  assign ret = a_x - b_x;

  // Guard bit disagreeing with the sign bit means the true difference left DW bits.
  always_comb begin
    r = ret[DW-1:0];
    if (ret[DW] != ret[DW-1]) begin
      r = ret[DW] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/mpc_vsub_rr_sched.sv
// Round-robin sequencer for the shared saturating vector-subtract datapath:
// grants one row pass at a time, streams reads, writes results one cycle later.
module mpc_vsub_rr_sched
  import mpc_vsub_pkg::*;
#(
  parameter int unsigned N_ELEM = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned DW     = 32,
  parameter int unsigned BW     = 21
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [N_REQ-1:0] req_start,
  output logic [N_REQ-1:0] req_done,
  output logic             busy,
  output logic [AW-1:0]    a_V_address0,
  output logic             a_V_ce0,
  input  logic [DW-1:0]    a_V_q0,
  output logic [AW:0]      b_V_address0,
  output logic             b_V_ce0,
  input  logic [BW-1:0]    b_V_q0,
  output logic [AW:0]      r_V_address0,
  output logic             r_V_ce0,
  output logic             r_V_we0,
  output logic [DW-1:0]    r_V_d0
);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [N_REQ-1:0]  pend_eff;
  logic              last_q, last_d;
  logic              gid_q, gid_d;
  logic              win;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     wr_idx_q;
  logic              wr_vld_q;
  logic              busy_q;

  // Starts arriving this cycle take part in arbitration immediately, so a
  // start at cycle t reads element 0 at t+1.
  assign pend_eff = pend_q | req_start;
  assign win      = (pend_eff == 2'b11) ? ~last_q : pend_eff[1];

  always_comb begin
    state_d = state_q;
    pend_d  = pend_eff;
    last_d  = last_q;
    gid_d   = gid_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (|pend_eff) begin
          state_d     = StRun;
          gid_d       = win;
          last_d      = win;
          pend_d[win] = 1'b0;
          idx_d       = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (idx_q == AW'(N_ELEM - 1)) begin
          state_d = StDrain;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      last_q   <= 1'b1;
      gid_q    <= 1'b0;
      idx_q    <= '0;
      wr_idx_q <= '0;
      wr_vld_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      idx_q    <= idx_d;
      wr_idx_q <= idx_q;
      wr_vld_q <= (state_q == StRun);
      busy_q   <= (state_d != StIdle);
    end
  end

  assign a_V_address0 = idx_q;
  assign a_V_ce0      = (state_q == StRun);
  assign b_V_address0 = {gid_q, idx_q};
  assign b_V_ce0      = (state_q == StRun);

  // gid_q only changes in IDLE/DONE, after the last write has drained.
  assign r_V_address0 = {gid_q, wr_idx_q};
  assign r_V_ce0      = wr_vld_q;
  assign r_V_we0      = wr_vld_q;

  assign req_done = (state_q == StDone) ? (N_REQ'(1) << gid_q) : '0;
  assign busy     = busy_q;

  mpc_sat_sub #(
    .DW(DW),
    .BW(BW)
  ) u_sat_sub (
    .a(a_V_q0),
    .b(b_V_q0),
    .r(r_V_d0)
  );

endmodule

// File: tb/tb_mpc_vsub_rr_sched.sv
// Self-checking bench for mpc_vsub_rr_sched: event logs plus a reference
// subtract model, checked per scenario.
module tb_mpc_vsub_rr_sched;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_start = 2'b00;
  logic [1:0]  req_done;
  logic        busy;
  logic [2:0]  a_addr;
  logic        a_ce;
  logic [31:0] a_q;
  logic [3:0]  b_addr;
  logic        b_ce;
  logic [20:0] b_q;
  logic [3:0]  r_addr;
  logic        r_ce;
  logic        r_we;
  logic [31:0] r_d;

  logic [31:0] a_mem [N];
  logic [20:0] b_mem [2*N];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [3:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t  wr_log[$];
  ev_t  rd_log[$];
  ev_t  done_log[$];
  logic busy_hist [int];

  mpc_vsub_rr_sched #(
    .N_ELEM(8),
    .AW(3),
    .DW(32),
    .BW(21)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .req_start(req_start),
    .req_done(req_done),
    .busy(busy),
    .a_V_address0(a_addr),
    .a_V_ce0(a_ce),
    .a_V_q0(a_q),
    .b_V_address0(b_addr),
    .b_V_ce0(b_ce),
    .b_V_q0(b_q),
    .r_V_address0(r_addr),
    .r_V_ce0(r_ce),
    .r_V_we0(r_we),
    .r_V_d0(r_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_ce) a_q <= a_mem[a_addr];
    if (b_ce) b_q <= b_mem[b_addr];
  end

  always @(negedge clk) begin
    if (r_we && r_ce) wr_log.push_back('{cyc, r_addr, r_d});
    if (b_ce) rd_log.push_back('{cyc, b_addr, 32'd0});
    if (req_done != 2'b00) done_log.push_back('{cyc, 4'(req_done), 32'd0});
    busy_hist[cyc] = busy;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1);
  end

  // Saturating difference computed on wide integers.
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [20:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    if (d > 2147483647) return 32'h7FFF_FFFF;
    if (d < -2147483647 - 1) return 32'h8000_0000;
    return d[31:0];
  endfunction

  function automatic logic [31:0] rnd_a();
    case ($urandom_range(3))
      0:       return 32'h7FFF_FF00 + $urandom_range(255);
      1:       return 32'h8000_0000 + $urandom_range(255);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [20:0] rnd_b();
    case ($urandom_range(3))
      0:       return 21'h10_0000;
      1:       return 21'h0F_FFFF;
      default: return 21'($urandom);
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) a_mem[i] = rnd_a();
    for (int i = 0; i < 2 * N; i++) b_mem[i] = rnd_b();
  endtask

  task automatic clear_logs();
    @(posedge clk);
    wr_log.delete();
    rd_log.delete();
    done_log.delete();
  endtask

  task automatic start(input logic [1:0] m, output int t);
    @(negedge clk);
    t = cyc;
    req_start = m;
    @(negedge clk);
    req_start = 2'b00;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (req_done !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b required 00", req_done); end
    if (a_ce !== 1'b0) begin n_err++; $display("FAIL reset_a_ce: got %b required 0", a_ce); end
    if (b_ce !== 1'b0) begin n_err++; $display("FAIL reset_b_ce: got %b required 0", b_ce); end
    if (r_ce !== 1'b0) begin n_err++; $display("FAIL reset_r_ce: got %b required 0", r_ce); end
    if (r_we !== 1'b0) begin n_err++; $display("FAIL reset_r_we: got %b required 0", r_we); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int t;
    for (int i = 0; i < N; i++) begin
      a_mem[i] = 32'(100 * i);
      b_mem[i] = 21'(i);
    end
    clear_logs();
    start(2'b01, t);
    wait_until(t + 13);
    for (int i = 0; i < N; i++) begin
      int hit = -1;
      foreach (wr_log[j]) if (wr_log[j].c == t + 2 + i) hit = j;
      n_cmp++;
      if (hit < 0) begin
        n_err++;
        $display("FAIL single_wr%0d: no write at cycle %0d, required one", i, t + 2 + i);
      end else if (wr_log[hit].addr !== 4'(i) || wr_log[hit].data !== 32'(99 * i)) begin
        n_err++;
        $display("FAIL single_wr%0d: got addr %0h data %0d required addr %0h data %0d", i,
                 wr_log[hit].addr, wr_log[hit].data, i, 99 * i);
      end
    end
    n_cmp += 4;
    if (wr_log.size() != N) begin
      n_err++; $display("FAIL single_wr_count: got %0d required %0d", wr_log.size(), N);
    end
    if (done_log.size() != 1 || done_log[0].c != t + 10 || done_log[0].addr !== 4'b0001) begin
      n_err++;
      $display("FAIL single_done: got %0d pulses (first cycle %0d) required one req0 pulse at %0d",
               done_log.size(), (done_log.size() > 0) ? done_log[0].c : -1, t + 10);
    end
    if (busy_hist[t + 1] !== 1'b1 || busy_hist[t + 10] !== 1'b1) begin
      n_err++; $display("FAIL single_busy_hi: got %b/%b required 1/1", busy_hist[t + 1],
                        busy_hist[t + 10]);
    end
    if (busy_hist[t] !== 1'b0 || busy_hist[t + 11] !== 1'b0) begin
      n_err++; $display("FAIL single_busy_lo: got %b/%b required 0/0", busy_hist[t],
                        busy_hist[t + 11]);
    end
  endtask

  task automatic test_saturation();
    int t;
    logic [31:0] expv [N];
    fill_random();
    a_mem[0] = 32'h7FFF_FFF0; b_mem[8]  = 21'h1F_FF00;
    a_mem[1] = 32'h8000_0010; b_mem[9]  = 21'd256;
    a_mem[2] = 32'd5;         b_mem[10] = 21'd7;
    for (int i = 0; i < N; i++) expv[i] = ref_sub(a_mem[i], b_mem[8 + i]);
    expv[0] = 32'h7FFF_FFFF;
    expv[1] = 32'h8000_0000;
    expv[2] = 32'hFFFF_FFFE;
    clear_logs();
    start(2'b10, t);
    wait_until(t + 12);
    for (int i = 0; i < N; i++) begin
      int hit = -1;
      foreach (wr_log[j]) if (wr_log[j].c == t + 2 + i) hit = j;
      n_cmp++;
      if (hit < 0) begin
        n_err++; $display("FAIL sat_wr%0d: no write at cycle %0d, required one", i, t + 2 + i);
      end else if (wr_log[hit].addr !== 4'(8 + i) || wr_log[hit].data !== expv[i]) begin
        n_err++;
        $display("FAIL sat_wr%0d: got addr %0h data %h required addr %0h data %h", i,
                 wr_log[hit].addr, wr_log[hit].data, 8 + i, expv[i]);
      end
    end
    n_cmp++;
    if (done_log.size() != 1 || done_log[0].c != t + 10 || done_log[0].addr !== 4'b0010) begin
      n_err++; $display("FAIL sat_done: got %0d pulses required one req1 pulse at %0d",
                        done_log.size(), t + 10);
    end
  endtask

  task automatic test_both();
    int t;
    int first1;
    do_reset();
    fill_random();
    clear_logs();
    start(2'b11, t);
    wait_until(t + 23);
    n_cmp += 2;
    if (done_log.size() != 2) begin
      n_err++; $display("FAIL both_done_count: got %0d required 2", done_log.size());
    end else if (done_log[0].c != t + 10 || done_log[0].addr !== 4'b0001 ||
                 done_log[1].c != t + 20 || done_log[1].addr !== 4'b0010) begin
      n_err++;
      $display("FAIL both_done_order: got %0b@%0d %0b@%0d required 01@%0d 10@%0d",
               done_log[0].addr, done_log[0].c, done_log[1].addr, done_log[1].c, t + 10, t + 20);
    end
    first1 = -1;
    foreach (rd_log[j]) if (first1 < 0 && rd_log[j].addr[3]) first1 = j;
    if (first1 < 0 || rd_log[first1].c != t + 11 || rd_log[first1].addr !== 4'b1000) begin
      n_err++; $display("FAIL both_rd1_start: got cycle %0d required cycle %0d addr 8",
                        (first1 < 0) ? -1 : rd_log[first1].c, t + 11);
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        int hit = -1;
        logic [31:0] e;
        e = ref_sub(a_mem[i], b_mem[8 * k + i]);
        foreach (wr_log[j]) if (wr_log[j].c == t + 2 + 10 * k + i) hit = j;
        n_cmp++;
        if (hit < 0) begin
          n_err++; $display("FAIL both_wr%0d_%0d: no write at cycle %0d", k, i, t + 2 + 10 * k + i);
        end else if (wr_log[hit].addr !== 4'(8 * k + i) || wr_log[hit].data !== e) begin
          n_err++;
          $display("FAIL both_wr%0d_%0d: got addr %0h data %h required addr %0h data %h", k, i,
                   wr_log[hit].addr, wr_log[hit].data, 8 * k + i, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    do_reset();
    clear_logs();
    @(negedge clk);
    t = cyc;
    req_start = 2'b11;
    repeat (35) @(negedge clk);
    req_start = 2'b00;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (done_log.size() < 4) begin
      n_err++; $display("FAIL alt_count: got %0d pulses required at least 4", done_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic [3:0] em;
        em = (k % 2 == 0) ? 4'b0001 : 4'b0010;
        n_cmp++;
        if (done_log[k].c != t + 10 + 10 * k || done_log[k].addr !== em) begin
          n_err++;
          $display("FAIL alt_grant%0d: got %0b@%0d required %0b@%0d", k, done_log[k].addr,
                   done_log[k].c, em, t + 10 + 10 * k);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 5; p++) begin
      int t;
      int k;
      k = $urandom_range(1);
      fill_random();
      clear_logs();
      start(2'(1 << k), t);
      wait_until(t + 12);
      for (int i = 0; i < N; i++) begin
        int hit = -1;
        logic [31:0] e;
        e = ref_sub(a_mem[i], b_mem[8 * k + i]);
        foreach (wr_log[j]) if (wr_log[j].c == t + 2 + i) hit = j;
        n_cmp++;
        if (hit < 0) begin
          n_err++; $display("FAIL rnd%0d_wr%0d: no write at cycle %0d", p, i, t + 2 + i);
        end else if (wr_log[hit].addr !== 4'(8 * k + i) || wr_log[hit].data !== e) begin
          n_err++;
          $display("FAIL rnd%0d_wr%0d: got addr %0h data %h required addr %0h data %h", p, i,
                   wr_log[hit].addr, wr_log[hit].data, 8 * k + i, e);
        end
      end
      n_cmp++;
      if (done_log.size() != 1 || done_log[0].c != t + 10 || done_log[0].addr !== 4'(1 << k)) begin
        n_err++; $display("FAIL rnd%0d_done: got %0d pulses required one at %0d", p,
                          done_log.size(), t + 10);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int late;
    fill_random();
    clear_logs();
    start(2'b01, t);
    wait_until(t + 3);
    req_start = 2'b10;
    @(negedge clk);
    req_start = 2'b00;
    wait_until(t + 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    if (a_ce !== 1'b0) begin n_err++; $display("FAIL rstmid_a_ce: got %b required 0", a_ce); end
    if (r_we !== 1'b0) begin n_err++; $display("FAIL rstmid_r_we: got %b required 0", r_we); end
    if (req_done !== 2'b00) begin
      n_err++; $display("FAIL rstmid_done_now: got %b required 00", req_done);
    end
    wait_until(t + 25);
    late = 0;
    foreach (wr_log[j]) if (wr_log[j].c > t + 5) late++;
    n_cmp += 4;
    if (late != 0) begin n_err++; $display("FAIL rstmid_late_wr: got %0d required 0", late); end
    if (wr_log.size() != 4) begin
      n_err++; $display("FAIL rstmid_wr_count: got %0d required 4", wr_log.size());
    end
    if (done_log.size() != 0) begin
      n_err++; $display("FAIL rstmid_done: got %0d pulses required 0", done_log.size());
    end
    if (busy_hist[t + 12] !== 1'b0) begin
      n_err++; $display("FAIL rstmid_pend_drop: busy got %b required 0", busy_hist[t + 12]);
    end
    clear_logs();
    start(2'b01, t);
    wait_until(t + 12);
    n_cmp += 2;
    if (wr_log.size() != N) begin
      n_err++; $display("FAIL rstmid_fresh_wr: got %0d required %0d", wr_log.size(), N);
    end
    if (done_log.size() != 1 || done_log[0].c != t + 10 || done_log[0].addr !== 4'b0001) begin
      n_err++; $display("FAIL rstmid_fresh_done: got %0d pulses required one at %0d",
                        done_log.size(), t + 10);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_both();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
